// File: rtl/pixel_packer.sv
// -----------------------------------------------------------------------------
// pixel_packer
//
// Packs 24-bit RGB pixels (one per input beat) into 32-bit AXI4-Stream words,
// four pixels per three words, little-endian with pixel 0 in the low bytes:
//     w0 = {p1[7:0],  p0}
//     w1 = {p2[15:0], p1[23:8]}
//     w2 = {p3,       p2[23:16]}
// Start-of-frame travels on tuser, end-of-line on tlast. A line whose length
// is not a multiple of four pixels is closed with a zero-padded flush word.
//
// Build option:
//     PACKER_ERR_FLAGS_EN  defined   -> line_err / frame_err are sticky flags
//                                       cleared by err_clr (set wins).
//                          undefined -> both flags read 0, err_clr ignored.
//
// Parameter:
//     TKEEP_PARTIAL  1: flush words mark only the valid bytes in tkeep
//                    0: tkeep is always 4'b1111 (padding bytes are zero)
//
// Ports:
//     out_stream_aclk      clock
//     periph_resetn        asynchronous reset, active low
//     in_data[23:0]        pixel {R, G, B}
//     in_valid / in_ready  input handshake (in_ready is combinational on tready)
//     in_sof               first pixel of the frame
//     in_eol               last pixel of the line
//     out_stream_t*        AXI4-Stream master (tuser = SOF, tlast = EOL)
//     err_clr              clears the sticky error flags
//     line_err             line length was not a multiple of 4 pixels
//     frame_err            SOF arrived in the middle of a 4-pixel group
//
// States:
//     state   | meaning
//     --------+-------------------------------------------------------------
//     S_RUN   | accepting pixels, emitting a word on phases 1..3
//     S_FLUSH | emitting the residue of a short line as a padded tlast word
// -----------------------------------------------------------------------------
module pixel_packer #(
    parameter int TKEEP_PARTIAL = 1
) (
    input  logic        out_stream_aclk,
    input  logic        periph_resetn,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic        in_eol,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        out_stream_tuser,
    output logic        out_stream_tlast,
    input  logic        err_clr,
    output logic        line_err,
    output logic        frame_err
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t      state_q,    state_d;
    logic [1:0]  phase_q,    phase_d;
    logic [23:0] residue_q,  residue_d;
    logic        sof_pend_q, sof_pend_d;

    logic [31:0] tdata_q,    tdata_d;
    logic [3:0]  tkeep_q,    tkeep_d;
    logic        tuser_q,    tuser_d;
    logic        tlast_q,    tlast_d;
    logic        tvalid_q,   tvalid_d;

    logic        out_load;
    logic        in_fire;
    logic [1:0]  eff_phase;
    logic        emit;
    logic        emit_last;
    logic [31:0] emit_word;
    logic [31:0] flush_word;
    logic [3:0]  flush_keep;
    logic        line_err_set;
    logic        frame_err_set;

    // The output register can take a new word when it is empty or draining.
    assign out_load = !tvalid_q || out_stream_tready;

    // A phase-0 pixel that does not end the line only fills the residue, so it
    // never needs the output register.
    assign in_ready = (state_q == S_RUN) &&
                      (((phase_q == 2'd0) && !in_eol) || out_load);

    assign in_fire = in_valid && in_ready;

    // A SOF restarts packing: the pixel is handled as the first of a group.
    assign eff_phase = in_sof ? 2'd0 : phase_q;

    // Residue holds 3, 2 or 1 valid bytes for phase 1, 2 or 3 respectively.
    always_comb begin
        flush_word = 32'h0000_0000;
        flush_keep = 4'b0001;
        case (phase_q)
            2'd1: begin
                flush_word = {8'h00, residue_q};
                flush_keep = 4'b0111;
            end
            2'd2: begin
                flush_word = {16'h0000, residue_q[15:0]};
                flush_keep = 4'b0011;
            end
            default: begin
                flush_word = {24'h00_0000, residue_q[7:0]};
                flush_keep = 4'b0001;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        residue_d     = residue_q;
        sof_pend_d    = sof_pend_q;
        tdata_d       = tdata_q;
        tkeep_d       = tkeep_q;
        tuser_d       = tuser_q;
        tlast_d       = tlast_q;
        tvalid_d      = tvalid_q;
        emit          = 1'b0;
        emit_last     = 1'b0;
        emit_word     = 32'h0000_0000;
        line_err_set  = 1'b0;
        frame_err_set = 1'b0;

        if (out_load) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            S_RUN: begin
                if (in_fire) begin
                    frame_err_set = in_sof && (phase_q != 2'd0);
                    case (eff_phase)
                        2'd0: begin
                            residue_d  = in_data;
                            sof_pend_d = sof_pend_q || in_sof;
                            phase_d    = 2'd1;
                        end
                        2'd1: begin
                            emit      = 1'b1;
                            emit_word = {in_data[7:0], residue_q};
                            residue_d = {8'h00, in_data[23:8]};
                            phase_d   = 2'd2;
                        end
                        2'd2: begin
                            emit      = 1'b1;
                            emit_word = {in_data[15:0], residue_q[15:0]};
                            residue_d = {16'h0000, in_data[23:16]};
                            phase_d   = 2'd3;
                        end
                        default: begin
                            emit      = 1'b1;
                            emit_word = {in_data, residue_q[7:0]};
                            emit_last = in_eol;
                            residue_d = 24'h00_0000;
                            phase_d   = 2'd0;
                        end
                    endcase

                    // Early end of line: the residue still has to go out.
                    if (in_eol && (eff_phase != 2'd3)) begin
                        state_d      = S_FLUSH;
                        line_err_set = 1'b1;
                    end

                    if (emit) begin
                        tdata_d    = emit_word;
                        tkeep_d    = 4'b1111;
                        tuser_d    = sof_pend_q;
                        tlast_d    = emit_last;
                        tvalid_d   = 1'b1;
                        sof_pend_d = 1'b0;
                    end
                end
            end

            S_FLUSH: begin
                if (out_load) begin
                    tdata_d    = flush_word;
                    tkeep_d    = (TKEEP_PARTIAL != 0) ? flush_keep : 4'b1111;
                    tuser_d    = sof_pend_q;
                    tlast_d    = 1'b1;
                    tvalid_d   = 1'b1;
                    sof_pend_d = 1'b0;
                    residue_d  = 24'h00_0000;
                    phase_d    = 2'd0;
                    state_d    = S_RUN;
                end
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q    <= S_RUN;
            phase_q    <= 2'd0;
            residue_q  <= 24'h00_0000;
            sof_pend_q <= 1'b0;
            tdata_q    <= 32'h0000_0000;
            tkeep_q    <= 4'b1111;
            tuser_q    <= 1'b0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            residue_q  <= residue_d;
            sof_pend_q <= sof_pend_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tuser_q    <= tuser_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = tkeep_q;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tvalid = tvalid_q;

`ifdef PACKER_ERR_FLAGS_EN
    logic line_err_q;
    logic frame_err_q;

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (line_err_set) begin
                line_err_q <= 1'b1;
            end else if (err_clr) begin
                line_err_q <= 1'b0;
            end
            if (frame_err_set) begin
                frame_err_q <= 1'b1;
            end else if (err_clr) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign line_err  = line_err_q;
    assign frame_err = frame_err_q;
`else
    logic [2:0] unused_err;
    assign unused_err = {err_clr, line_err_set, frame_err_set};
    assign line_err   = 1'b0;
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
module tb_pixel_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] in_data = 24'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        tuser;
    logic        tlast;
    logic        err_clr = 1'b0;
    logic        line_err;
    logic        frame_err;

`ifdef PACKER_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Captured words: {tdata, tkeep, tuser, tlast}
    logic [37:0] words[$];
    logic        rand_ready = 1'b0;
    logic        stall_q = 1'b0;
    logic [37:0] stall_word = '0;

    logic [23:0] pix[640];
    logic [7:0]  bytes_m[1920];

    always #5 clk = ~clk;

    pixel_packer dut (
        .out_stream_aclk  (clk),
        .periph_resetn    (rst_n),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_sof           (in_sof),
        .in_eol           (in_eol),
        .out_stream_tdata (tdata),
        .out_stream_tkeep (tkeep),
        .out_stream_tvalid(tvalid),
        .out_stream_tready(tready),
        .out_stream_tuser (tuser),
        .out_stream_tlast (tlast),
        .err_clr          (err_clr),
        .line_err         (line_err),
        .frame_err        (frame_err)
    );

    // Output monitor: sampled mid-cycle, collects handshaken words and checks
    // that a stalled word is held unchanged.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    n_cmp++;
                    if (tvalid !== 1'b1 || {tdata, tkeep, tuser, tlast} !== stall_word) begin
                        n_err++;
                        $display("FAIL stall_hold got v=%b %h exp v=1 %h", tvalid,
                                 {tdata, tkeep, tuser, tlast}, stall_word);
                    end
                end
                if (tvalid === 1'b1 && tready === 1'b1) words.push_back({tdata, tkeep, tuser, tlast});
                stall_q    = (tvalid === 1'b1) && (tready === 1'b0);
                stall_word = {tdata, tkeep, tuser, tlast};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) tready = 1'($urandom_range(0, 1));
        end
    end

    // Entered and left at posedge+1.
    task automatic send_pix(input logic [23:0] d, input logic s, input logic e, output int stalls);
        int n;
        n = 0;
        in_data  = d;
        in_sof   = s;
        in_eol   = e;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        stalls = n;
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout got in_ready=%b exp 1 within 200 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (words.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({tvalid, tuser, tlast} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 000", {tvalid, tuser, tlast});
        end
        n_cmp++;
        if (tdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_tdata got %h exp 00000000", tdata);
        end
        n_cmp++;
        if (tkeep !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_tkeep got %b exp 1111", tkeep);
        end
        n_cmp++;
        if ({line_err, frame_err} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_flags got %b exp 00", {line_err, frame_err});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [37:0] exp_w[3];
        logic [37:0] got;
        int st, tot;
        exp_w[0] = {32'h04030201, 4'hF, 1'b1, 1'b0};
        exp_w[1] = {32'h08070605, 4'hF, 1'b0, 1'b0};
        exp_w[2] = {32'h0C0B0A09, 4'hF, 1'b0, 1'b1};
        tready = 1'b1;
        words.delete();
        tot = 0;
        send_pix(24'h030201, 1'b1, 1'b0, st); tot += st;
        send_pix(24'h060504, 1'b0, 1'b0, st); tot += st;
        n_cmp++;
        if ({tvalid, tdata, tuser} !== {1'b1, 32'h04030201, 1'b1}) begin
            n_err++;
            $display("FAIL basic_latency got v=%b %h u=%b exp v=1 04030201 u=1", tvalid, tdata, tuser);
        end
        send_pix(24'h090807, 1'b0, 1'b0, st); tot += st;
        send_pix(24'h0C0B0A, 1'b0, 1'b1, st); tot += st;
        wait_words(3, 50);
        n_cmp++;
        if (words.size() != 3) begin
            n_err++;
            $display("FAIL basic_count got %0d exp 3", words.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < words.size()) ? words[i] : 'x;
            n_cmp++;
            if (got !== exp_w[i]) begin
                n_err++;
                $display("FAIL basic_word%0d got %h exp %h", i, got, exp_w[i]);
            end
        end
        n_cmp++;
        if (tot != 0) begin
            n_err++;
            $display("FAIL basic_stalls got %0d exp 0", tot);
        end
    endtask

    task automatic test_back_to_back();
        logic [37:0] exp_w[6];
        logic [37:0] got;
        int st, tot;
        exp_w[0] = {32'h02010101, 4'hF, 1'b0, 1'b0};
        exp_w[1] = {32'h03030202, 4'hF, 1'b0, 1'b0};
        exp_w[2] = {32'h04040403, 4'hF, 1'b0, 1'b1};
        exp_w[3] = {32'h06050505, 4'hF, 1'b0, 1'b0};
        exp_w[4] = {32'h07070606, 4'hF, 1'b0, 1'b0};
        exp_w[5] = {32'h08080807, 4'hF, 1'b0, 1'b1};
        tready = 1'b1;
        words.delete();
        tot = 0;
        for (int i = 1; i <= 8; i++) begin
            send_pix({3{8'(i)}}, 1'b0, (i % 4) == 0, st);
            tot += st;
        end
        wait_words(6, 50);
        n_cmp++;
        if (words.size() != 6) begin
            n_err++;
            $display("FAIL b2b_count got %0d exp 6", words.size());
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < words.size()) ? words[i] : 'x;
            n_cmp++;
            if (got !== exp_w[i]) begin
                n_err++;
                $display("FAIL b2b_word%0d got %h exp %h", i, got, exp_w[i]);
            end
        end
        n_cmp++;
        if (tot != 0) begin
            n_err++;
            $display("FAIL b2b_stalls got %0d exp 0", tot);
        end
    endtask

    task automatic test_short_line();
        logic [37:0] exp_w[4];
        logic [37:0] got;
        int st;
        exp_w[0] = {32'h22111111, 4'hF,    1'b1, 1'b0};
        exp_w[1] = {32'h33332222, 4'hF,    1'b0, 1'b0};
        exp_w[2] = {32'h44444433, 4'hF,    1'b0, 1'b0};
        exp_w[3] = {32'h00555555, 4'b0111, 1'b0, 1'b1};
        tready = 1'b1;
        words.delete();
        send_pix(24'h111111, 1'b1, 1'b0, st);
        send_pix(24'h222222, 1'b0, 1'b0, st);
        send_pix(24'h333333, 1'b0, 1'b0, st);
        send_pix(24'h444444, 1'b0, 1'b0, st);
        send_pix(24'h555555, 1'b0, 1'b1, st);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL short_flush_ready got %b exp 0", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL short_after_flush_ready got %b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        wait_words(4, 50);
        n_cmp++;
        if (words.size() != 4) begin
            n_err++;
            $display("FAIL short_count got %0d exp 4", words.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < words.size()) ? words[i] : 'x;
            n_cmp++;
            if (got !== exp_w[i]) begin
                n_err++;
                $display("FAIL short_word%0d got %h exp %h", i, got, exp_w[i]);
            end
        end
        n_cmp++;
        if (line_err !== ERR_EN) begin
            n_err++;
            $display("FAIL short_line_err got %b exp %b", line_err, ERR_EN);
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        n_cmp++;
        if (line_err !== 1'b0) begin
            n_err++;
            $display("FAIL short_line_err_clr got %b exp 0", line_err);
        end
    endtask

    task automatic test_sof_mid();
        logic [37:0] exp_w[4];
        logic [37:0] got;
        int st;
        exp_w[0] = {32'hB3A1A2A3, 4'hF, 1'b0, 1'b0};
        exp_w[1] = {32'hD3C1C2C3, 4'hF, 1'b1, 1'b0};
        exp_w[2] = {32'hE2E3D1D2, 4'hF, 1'b0, 1'b0};
        exp_w[3] = {32'hF1F2F3E1, 4'hF, 1'b0, 1'b1};
        tready = 1'b1;
        words.delete();
        send_pix(24'hA1A2A3, 1'b0, 1'b0, st);
        send_pix(24'hB1B2B3, 1'b0, 1'b0, st);
        send_pix(24'hC1C2C3, 1'b1, 1'b0, st);
        send_pix(24'hD1D2D3, 1'b0, 1'b0, st);
        send_pix(24'hE1E2E3, 1'b0, 1'b0, st);
        send_pix(24'hF1F2F3, 1'b0, 1'b1, st);
        wait_words(4, 50);
        n_cmp++;
        if (words.size() != 4) begin
            n_err++;
            $display("FAIL sofmid_count got %0d exp 4", words.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < words.size()) ? words[i] : 'x;
            n_cmp++;
            if (got !== exp_w[i]) begin
                n_err++;
                $display("FAIL sofmid_word%0d got %h exp %h", i, got, exp_w[i]);
            end
        end
        n_cmp++;
        if ({frame_err, line_err} !== {ERR_EN, 1'b0}) begin
            n_err++;
            $display("FAIL sofmid_flags got %b exp %b", {frame_err, line_err}, {ERR_EN, 1'b0});
        end
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL sofmid_frame_err_clr got %b exp 0", frame_err);
        end
    endtask

    task automatic test_long_line();
        logic [37:0] expw;
        logic [37:0] got;
        int st;
        for (int i = 0; i < 640; i++) begin
            pix[i] = 24'($urandom);
            for (int j = 0; j < 3; j++) bytes_m[3*i+j] = pix[i][8*j +: 8];
        end
        words.delete();
        rand_ready = 1'b1;
        for (int i = 0; i < 640; i++) begin
            send_pix(pix[i], i == 0, i == 639, st);
        end
        wait_words(480, 3000);
        rand_ready = 1'b0;
        tready = 1'b1;
        n_cmp++;
        if (words.size() != 480) begin
            n_err++;
            $display("FAIL long_count got %0d exp 480", words.size());
        end
        for (int k = 0; k < 480; k++) begin
            expw = {bytes_m[4*k+3], bytes_m[4*k+2], bytes_m[4*k+1], bytes_m[4*k],
                    4'hF, k == 0, k == 479};
            got = (k < words.size()) ? words[k] : 'x;
            n_cmp++;
            if (got !== expw) begin
                n_err++;
                $display("FAIL long_word%0d got %h exp %h", k, got, expw);
            end
        end
        n_cmp++;
        if (line_err !== 1'b0) begin
            n_err++;
            $display("FAIL long_line_err got %b exp 0", line_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [37:0] exp_w[3];
        logic [37:0] got;
        int st;
        exp_w[0] = {32'h60102030, 4'hF, 1'b0, 1'b0};
        exp_w[1] = {32'h80904050, 4'hF, 1'b0, 1'b0};
        exp_w[2] = {32'hA0B0C070, 4'hF, 1'b0, 1'b1};
        tready = 1'b1;
        send_pix(24'h123456, 1'b1, 1'b0, st);
        send_pix(24'h789ABC, 1'b0, 1'b0, st);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tvalid, tuser, tlast, tdata, tkeep} !== {3'b000, 32'h0, 4'hF}) begin
            n_err++;
            $display("FAIL rstmid_outputs got v=%b u=%b l=%b %h %b exp 0 0 0 00000000 1111",
                     tvalid, tuser, tlast, tdata, tkeep);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        words.delete();
        @(negedge clk);
        n_cmp++;
        if ({in_ready, tvalid} !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, tvalid);
        end
        @(posedge clk);
        #1;
        send_pix(24'h102030, 1'b0, 1'b0, st);
        send_pix(24'h405060, 1'b0, 1'b0, st);
        send_pix(24'h708090, 1'b0, 1'b0, st);
        send_pix(24'hA0B0C0, 1'b0, 1'b1, st);
        wait_words(3, 50);
        n_cmp++;
        if (words.size() != 3) begin
            n_err++;
            $display("FAIL rstmid_count got %0d exp 3", words.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < words.size()) ? words[i] : 'x;
            n_cmp++;
            if (got !== exp_w[i]) begin
                n_err++;
                $display("FAIL rstmid_word%0d got %h exp %h", i, got, exp_w[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_short_line();
        test_sof_mid();
        test_long_line();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
# pixel_packer

Packs a stream of 24-bit RGB pixels, one per beat, into the 32-bit AXI4-Stream words driven on `out_stream_*`, so that four pixels become three words. It sits between the pixel computation pipeline and the AXI4-Stream output of `pixel_generator`. It propagates start-of-frame on `tuser` and end-of-line on `tlast`. A 640-pixel line therefore leaves as 480 words.

## Interface
- `TKEEP_PARTIAL`, default 1: 1 = partial flush words drive `tkeep` with only the valid bytes set; 0 = `tkeep` is always 4'b1111 and unused bytes are zero.
- `out_stream_aclk` in 1: the single clock.
- `periph_resetn` in 1: asynchronous reset, active-low.
- `in_data` in 24: pixel as {R[23:16], G[15:8], B[7:0]}.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_sof` in 1: first pixel of the frame.
- `in_eol` in 1: last pixel of the line.
- `out_stream_tdata` out 32, `out_stream_tkeep` out 4, `out_stream_tvalid` out 1, `out_stream_tready` in 1, `out_stream_tuser` out 1 (SOF), `out_stream_tlast` out 1 (EOL).
- `err_clr` in 1: clears the sticky error flags.
- `line_err` out 1: sticky; line length was not a multiple of 4 pixels.
- `frame_err` out 1: sticky; SOF arrived mid-group.

## Operation
- Byte order is little-endian, pixel 0 first.
  - w0 = {p1[7:0], p0}
  - w1 = {p2[15:0], p1[23:8]}
  - w2 = {p3, p2[23:16]}
- State:
  - `phase` (0..3)
  - 24-bit `residue`
  - `sof_pend` flag
  - FSM {RUN, FLUSH}
  - one output register stage (data, keep, user, last, valid)
- Accepting a pixel in RUN:
  - phase 0: the pixel goes into `residue`; no word is emitted.
  - phases 1, 2 and 3: each emits one word built from the residue bytes plus the new pixel bytes, and the leftover bytes go into `residue` (3→6→emit 4, rest 2→5→emit 4, rest 1→4→emit 4, rest 0).
  - `phase` increments mod 4.
- `in_sof` accepted at phase 0 sets `sof_pend`. The next emitted word carries `tuser`=1, and `sof_pend` then clears.
- `in_sof` accepted at phase ≠ 0:
  - `residue` is discarded and `frame_err` is set.
  - The pixel is treated as phase 0 with `sof_pend` set.
- `in_eol` at phase 3: the emitted word has `tlast`=1, and `phase` becomes 0.
- `in_eol` at phase 0, 1 or 2 (malformed line):
  - At phase 1 or 2 the word completed by this pixel is emitted with `tlast`=0.
  - The FSM then enters FLUSH and `line_err` is set.
- FLUSH:
  - Emits one word holding the residue bytes (3, 2 or 1 bytes), zero-padded in the upper bytes.
  - `tkeep` is 4'b0111, 4'b0011 or 4'b0001 when `TKEEP_PARTIAL`=1.
  - `tlast`=1; `tuser` is set if `sof_pend` is set.
  - `phase` becomes 0 and the FSM returns to RUN.
- `in_ready`:
  - In RUN, it is 1 when the pixel would not emit a word (phase 0 and not `in_eol`). Otherwise it is `!tvalid || tready`.
  - It is 0 in FLUSH.
  - This is a combinational path from `out_stream_tready`.
- `err_clr` clears both flags. Same-cycle priority: set wins over clear.

## Timing
- Reset values (asynchronous):
  - `tvalid`, `tuser`, `tlast`, `tdata`, `line_err`, `frame_err` = 0
  - `tkeep` = 4'b1111
  - phase = 0, FSM = RUN, `sof_pend` = 0
  - `in_ready` = 1 once out of reset
- Latency: a word is valid on `out_stream_*` in the cycle after the completing pixel handshake.
- Output register:
  - Loads when `!tvalid || tready`.
  - Holds `tdata`/`tkeep`/`tuser`/`tlast` stable while `tvalid && !tready`.
  - `tvalid` never drops without a handshake.
- Throughput: with `tready` held at 1, one pixel per cycle is accepted sustained, and the output is 3 words per 4 cycles.
- A FLUSH costs one extra cycle, plus any backpressure stall.
- Reset mid-line: the residue, the pending word and the FSM are discarded immediately, with no partial output afterwards.
- `tuser` and `tlast` can both be 1 on the same word (single-group line, or a flush word carrying a pending SOF).

## Configuration
- `PACKER_ERR_FLAGS_EN`:
  - Defined: `line_err`/`frame_err` are sticky registers as described, and `err_clr` is honoured.
  - Undefined: both outputs are tied to 0, `err_clr` is ignored, and no flag registers exist.
- Packing, FLUSH and SOF/EOL behaviour are identical in both builds.

## Test plan
- Four pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A with `in_sof` on the first and `in_eol` on the last, `tready`=1 → words 0x04030201 (`tuser`=1), 0x08070605, 0x0C0B0A09 (`tlast`=1), `tkeep`=4'b1111.
- A 640-pixel line with `in_eol` on the last pixel under 50% random `tready` → exactly 480 words, `tlast` only on word 479, no data change while stalled, no `line_err`.
- A 5-pixel line (p0..p4 = 0x111111..0x555555) with `in_eol` on p4 → 3 full words, then a flush word 0x00555555 with `tkeep`=4'b0111 and `tlast`=1; `line_err`=1; `in_ready`=0 for the FLUSH cycle.
- `in_sof` on the 3rd pixel of a group → `frame_err`=1, the residue is dropped, the next word starts with the SOF pixel and has `tuser`=1; after `err_clr` pulse, `frame_err`=0.
- `periph_resetn` pulsed low after 2 pixels of a line → all outputs at reset values at once; after release the next 4 pixels produce 3 clean words.
- Build without `PACKER_ERR_FLAGS_EN` and rerun the 5-pixel case → same words, `line_err` stays 0.
